// File: rtl/uart_hamming_pkg.sv
// Hamming(7,4) types, bit positions and helpers shared by the UART
// receive decoder and the transmit-side encoder.
// No ports: package only.
package uart_hamming_pkg;

    localparam int CW_W  = 7;
    localparam int NIB_W = 4;

    // Codeword bit positions, cw[i] is Hamming position i+1.
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D1_POS = 2;
    localparam int P4_POS = 3;
    localparam int D2_POS = 4;
    localparam int D3_POS = 5;
    localparam int D4_POS = 6;

    typedef logic [CW_W-1:0]  cw_t;
    typedef logic [NIB_W-1:0] nib_t;
    typedef logic [2:0]       syn_t;

    typedef struct packed {
        logic corr;
        nib_t data;
    } nib_entry_t;

    function automatic cw_t ham74_encode(input nib_t n);
        cw_t cw;
        cw         = '0;
        cw[D1_POS] = n[0];
        cw[D2_POS] = n[1];
        cw[D3_POS] = n[2];
        cw[D4_POS] = n[3];
        cw[P1_POS] = n[0] ^ n[1] ^ n[3];
        cw[P2_POS] = n[0] ^ n[2] ^ n[3];
        cw[P4_POS] = n[1] ^ n[2] ^ n[3];
        return cw;
    endfunction

    // s = {s4,s2,s1}; a nonzero value names the flipped position.
    function automatic syn_t ham74_syndrome(input cw_t cw);
        syn_t s;
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return s;
    endfunction

    function automatic cw_t ham74_correct(
        input cw_t  cw,
        input syn_t s
    );
        cw_t fixed;
        fixed = cw;
        for (int i = 0; i < CW_W; i++) begin
            if (s == syn_t'(i + 1)) begin
                fixed[i] = ~cw[i];
            end
        end
        return fixed;
    endfunction

    function automatic nib_t ham74_data(input cw_t cw);
        return {cw[D4_POS], cw[D3_POS], cw[D2_POS], cw[D1_POS]};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; push and pop may happen in the same
// cycle, including when full.
// Ports: clk, rst (sync, active-high), push/push_data,
//        pop, rd_data (head), full, empty.
module uart_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop frees the slot this cycle, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count
                   + {{AW{1'b0}}, push_ok}
                   - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/hamming74_rx_decoder.sv
// Hamming(7,4) decode stage behind the UART receiver: syndrome,
// single-bit correction, nibble FIFO with valid/ready output.
// Ports: clk, rst (sync, active-high), ena, code_in[6:0], code_valid,
//        nibble_out[3:0], nibble_corr, nibble_valid, nibble_ready,
//        overflow (sticky), err_count[CNT_W-1:0].
// Build option: HAMMING_ERR_COUNT_EN enables the saturating
// corrected-word counter; otherwise err_count is tied to 0.
module hamming74_rx_decoder
    import uart_hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [6:0]       code_in,
    input  logic             code_valid,
    output logic [3:0]       nibble_out,
    output logic             nibble_corr,
    output logic             nibble_valid,
    input  logic             nibble_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] err_count
);

    logic       s1_valid;
    cw_t        s1_cw;
    syn_t       s1_syn;
    cw_t        fixed_cw;
    nib_entry_t push_entry;
    logic [$bits(nib_entry_t)-1:0] head_bits;
    nib_entry_t head;
    nib_entry_t last_q;
    logic       full;
    logic       empty;
    logic       push_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
        end else begin
            s1_valid <= code_valid && ena;
            if (code_valid && ena) begin
                s1_cw  <= code_in;
                s1_syn <= ham74_syndrome(code_in);
            end
        end
    end

    always_comb begin
        fixed_cw        = ham74_correct(s1_cw, s1_syn);
        push_entry.corr = |s1_syn;
        push_entry.data = ham74_data(fixed_cw);
    end

    uart_sync_fifo #(
        .WIDTH ($bits(nib_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (nibble_ready),
        .rd_data   (head_bits),
        .full      (full),
        .empty     (empty)
    );

    assign head      = head_bits;
    assign push_drop = s1_valid && full && !nibble_ready;

    // last_q keeps the most recent head so the outputs hold when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            last_q   <= '0;
        end else begin
            if (push_drop) begin
                overflow <= 1'b1;
            end
            if (!empty) begin
                last_q <= head;
            end
        end
    end

    assign nibble_valid = !empty;
    assign {nibble_corr, nibble_out} = empty ? last_q : head;

`ifdef HAMMING_ERR_COUNT_EN
    logic [CNT_W-1:0] err_q;
    logic             push_acc;

    assign push_acc = s1_valid && !push_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (push_acc && push_entry.corr && !(&err_q)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule
